// File: rtl/muladd_vec.sv
// rtl/muladd_vec.sv - dot product of two operand memories with optional signed operands and saturation
// Read pipeline: address issue -> memory read -> operand capture -> product -> accumulate.
module muladd_vec #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ACC_W  = 32,
  parameter bit SIGNED = 1'b0,
  parameter bit SAT    = 1'b0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic [ADDR_W:0]   len,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [ADDR_W-1:0] a_address0,
  output logic              a_ce0,
  input  logic [DATA_W-1:0] a_q0,
  output logic [ADDR_W-1:0] b_address0,
  output logic              b_ce0,
  input  logic [DATA_W-1:0] b_q0,
  output logic [ACC_W-1:0]  ap_return,
  output logic              ap_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam int              PROD_W  = 2 * DATA_W;
  localparam logic [ADDR_W:0] MAX_N   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_N   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W:0]   n_len;
  logic [ADDR_W:0]   len_clamp;
  logic [ADDR_W-1:0] cnt;
  logic              start_acc;
  logic              fetch_last;
  logic              rd_vld;
  logic              cap_vld;
  logic              prd_vld;
  logic [DATA_W-1:0] a_cap;
  logic [DATA_W-1:0] b_cap;
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] prod_nx;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  p_sext;
  logic [ACC_W-1:0]  p_zext;
  logic [ACC_W-1:0]  p_ext;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nx;
  logic [ACC_W-1:0]  sat_val;
  logic [ACC_W:0]    sum;
  logic              add_ovf;
  logic              ovf;

  assign start_acc  = (state == S_IDLE) && ap_start;
  assign len_clamp  = (len > MAX_N) ? MAX_N : len;
  assign fetch_last = ({1'b0, cnt} == (n_len - ONE_N));

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; the drain ends on the edge that accumulates the final product
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (ap_start) begin
          state_nx = (len_clamp == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch_last) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (prd_vld && !cap_vld) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    ap_idle    = (state == S_IDLE);
    ap_done    = (state == S_DONE);
    ap_ready   = ((state == S_FETCH) && fetch_last) || ((state == S_DONE) && (n_len == '0));
    a_ce0      = (state == S_FETCH);
    b_ce0      = (state == S_FETCH);
    a_address0 = (state == S_FETCH) ? cnt : '0;
    b_address0 = (state == S_FETCH) ? cnt : '0;
    ap_return  = acc;
    ap_ovf     = ovf;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      n_len <= '0;
      cnt   <= '0;
    end else if (start_acc) begin
      n_len <= len_clamp;
      cnt   <= '0;
    end else if (state == S_FETCH) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Valid chain tracking each issued address through the read, capture and product stages
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_vld  <= 1'b0;
      cap_vld <= 1'b0;
      prd_vld <= 1'b0;
      a_cap   <= '0;
      b_cap   <= '0;
      prod    <= '0;
    end else begin
      rd_vld  <= (state == S_FETCH);
      cap_vld <= rd_vld;
      prd_vld <= cap_vld;
      if (rd_vld) begin
        a_cap <= a_q0;
        b_cap <= b_q0;
      end
      if (cap_vld) begin
        prod <= prod_nx;
      end
    end
  end

  // Extending operands to the full product width keeps the low product bits exact for both signednesses
  assign a_ext   = SIGNED ? PROD_W'($signed(a_cap)) : PROD_W'(a_cap);
  assign b_ext   = SIGNED ? PROD_W'($signed(b_cap)) : PROD_W'(b_cap);
  assign prod_nx = a_ext * b_ext;

  assign p_sext = ACC_W'($signed(prod));
  assign p_zext = ACC_W'(prod);
  assign p_ext  = SIGNED ? p_sext : p_zext;

  assign sum     = {SIGNED & acc[ACC_W-1], acc} + {SIGNED & p_ext[ACC_W-1], p_ext};
  assign add_ovf = SIGNED ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];

  always_comb begin
    sat_val = '1;
    if (SIGNED) begin
      sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign acc_nx = (SAT && add_ovf) ? sat_val : sum[ACC_W-1:0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (start_acc) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (prd_vld) begin
      acc <= acc_nx;
      ovf <= ovf | add_ovf;
    end
  end

endmodule

// File: tb/tb_muladd_vec.sv
// tb/tb_muladd_vec.sv - scoreboard bench for muladd_vec in unsigned/signed, wrap/saturate variants
module tb_muladd_vec;

  localparam int NI = 4;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic [4:0]  len = 5'd0;
  logic [15:0] a_mem [16];
  logic [15:0] b_mem [16];

  logic [NI-1:0] done_v;
  logic [NI-1:0] idle_v;
  logic [NI-1:0] ready_v;
  logic [NI-1:0] ce_v;
  logic [NI-1:0] ovf_v;
  logic [31:0]   ret_v [NI];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input bit sg, input bit st, input int n);
    longint acc;
    longint p;
    longint hi;
    longint lo;
    bit     ov;
    acc = 0;
    ov  = 1'b0;
    hi  = sg ? 64'sd2147483647 : 64'sd4294967295;
    lo  = sg ? -64'sd2147483648 : 64'sd0;
    for (int k = 0; k < n; k++) begin
      if (sg) p = longint'($signed(a_mem[k])) * longint'($signed(b_mem[k]));
      else    p = longint'({48'b0, a_mem[k]}) * longint'({48'b0, b_mem[k]});
      acc = acc + p;
      if (acc > hi) begin
        ov  = 1'b1;
        acc = st ? hi : acc - 64'sd4294967296;
      end else if (acc < lo) begin
        ov  = 1'b1;
        acc = st ? lo : acc + 64'sd4294967296;
      end
    end
    return {ov, acc[31:0]};
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam bit SG = (gi % 2) == 1;
    localparam bit ST = gi >= 2;

    logic        done, idle, ready, a_ce, b_ce, ovf;
    logic [3:0]  a_addr, b_addr;
    logic [15:0] a_q, b_q;
    logic [31:0] ret;
    logic [32:0] exp_q [$];
    logic [32:0] exp_r;
    logic [32:0] last_r = '0;
    logic [4:0]  len_s = '0;
    logic [3:0]  e_addr;
    bit          running = 1'b0;
    bit          armed = 1'b0;
    bit          armed_nx;
    bit          e_done, e_ready, e_ce;
    int          e0 = 0;
    int          n = 0;
    int          d;

    muladd_vec #(.SIGNED(SG), .SAT(ST)) u_dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .ap_start   (ap_start),
      .len        (len),
      .ap_done    (done),
      .ap_idle    (idle),
      .ap_ready   (ready),
      .a_address0 (a_addr),
      .a_ce0      (a_ce),
      .a_q0       (a_q),
      .b_address0 (b_addr),
      .b_ce0      (b_ce),
      .b_q0       (b_q),
      .ap_return  (ret),
      .ap_ovf     (ovf)
    );

    assign done_v[gi]  = done;
    assign idle_v[gi]  = idle;
    assign ready_v[gi] = ready;
    assign ce_v[gi]    = a_ce | b_ce;
    assign ovf_v[gi]   = ovf;
    assign ret_v[gi]   = ret;

    // Operand memories: one-cycle read latency, garbage when not enabled
    always @(posedge ap_clk) begin
      a_q <= a_ce ? a_mem[a_addr] : 16'($urandom);
      b_q <= b_ce ? b_mem[b_addr] : 16'($urandom);
    end

    always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
        check($sformatf("rst_ctrl%0d", gi), {idle, done, ready, a_ce, b_ce, a_addr, b_addr}, 13'h1000);
        check($sformatf("rst_result%0d", gi), {ovf, ret}, 33'h0);
        running = 1'b0;
        armed   = 1'b0;
        exp_q.delete();
        last_r  = '0;
      end else begin
        if (armed) begin
          running = 1'b1;
          e0      = cyc;
          n       = (len_s > 5'd16) ? 16 : int'(len_s);
          exp_q.push_back(model(SG, ST, n));
        end
        d       = cyc - e0;
        e_done  = running && (d == ((n == 0) ? 0 : n + 3));
        e_ready = running && (d == ((n == 0) ? 0 : n - 1));
        e_ce    = running && (d < n);
        e_addr  = e_ce ? 4'(d) : 4'd0;
        check($sformatf("ctrl%0d", gi), {idle, done, ready, a_ce, b_ce, a_addr, b_addr},
              {!running, e_done, e_ready, e_ce, e_ce, e_addr, e_addr});
        if (!running) check($sformatf("held%0d", gi), {ovf, ret}, last_r);
        armed_nx = !running && ap_start;
        if (done) begin
          if (exp_q.size() == 0) begin
            check($sformatf("spurious_done%0d", gi), done, 1'b0);
          end else begin
            exp_r = exp_q.pop_front();
            check($sformatf("return%0d", gi), ret, exp_r[31:0]);
            check($sformatf("ovf%0d", gi), ovf, exp_r[32]);
            last_r = exp_r;
          end
        end
        if (e_done) running = 1'b0;
        armed = armed_nx;
        len_s = len;
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge ap_clk);
      #2;
    end
  endtask

  task automatic run(input logic [4:0] l, input bit hold_start);
    bit seen_ready = 1'b0;
    bit seen_done  = 1'b0;
    ap_start = 1'b1;
    len      = l;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      tick(1);
      if (ready_v[0]) begin
        seen_ready = 1'b1;
        if (!hold_start) begin
          ap_start = 1'b0;
          len      = 5'($urandom);
        end
      end
      if (done_v[0]) seen_done = 1'b1;
    end
    check("run_handshake", {seen_ready, seen_done}, 2'b11);
    if (!hold_start) ap_start = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = 16'(i);
      b_mem[i] = 16'(i + 1);
    end
  endtask

  task automatic fill_const(input logic [15:0] av, input logic [15:0] bv);
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = av;
      b_mem[i] = bv;
    end
  endtask

  initial begin
    fill_ramp();
    tick(3);
    ap_rst_n = 1'b1;
    tick(2);

    run(5'd16, 1'b0);
    check("ramp16_ret", ret_v[0], 32'h0000_0550);
    check("ramp16_ovf", ovf_v[0], 1'b0);
    tick(2);

    run(5'd0, 1'b0);
    check("len0_ret", ret_v[0], 32'h0);
    tick(2);

    run(5'd20, 1'b0);
    check("len20_ret", ret_v[0], 32'h0000_0550);
    tick(2);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        a_mem[i] = 16'($urandom);
        b_mem[i] = 16'($urandom);
      end
      run(5'($urandom_range(1, 16)), 1'b0);
      tick(2);
    end

    fill_const(16'hFFFF, 16'h0002);
    run(5'd4, 1'b0);
    check("signed_neg_ret", ret_v[1], 32'hFFFF_FFF8);
    check("signed_neg_ovf", ovf_v[1], 1'b0);
    tick(2);

    fill_const(16'hFFFF, 16'hFFFF);
    run(5'd4, 1'b0);
    check("wrap_ret", ret_v[0], 32'hFFF8_0004);
    check("wrap_ovf", ovf_v[0], 1'b1);
    check("sat_ret", ret_v[2], 32'hFFFF_FFFF);
    check("sat_ovf", ovf_v[2], 1'b1);
    tick(2);

    // Signed: clamp at max, then pulled back into range by negative products
    fill_const(16'h7FFF, 16'h7FFF);
    for (int i = 3; i < 6; i++) a_mem[i] = 16'h8000;
    run(5'd6, 1'b0);
    tick(2);

    fill_const(16'h8000, 16'h8000);
    run(5'd4, 1'b0);
    check("ssat_max_ret", ret_v[3], 32'h7FFF_FFFF);
    tick(2);

    fill_const(16'h8000, 16'h7FFF);
    run(5'd4, 1'b0);
    check("ssat_min_ret", ret_v[3], 32'h8000_0000);
    tick(2);

    // Abort a run in the middle of its fetch phase
    fill_ramp();
    ap_start = 1'b1;
    len      = 5'd16;
    tick(6);
    ap_rst_n = 1'b0;
    #1;
    check("async_rst_idle", idle_v, 4'hF);
    check("async_rst_done", done_v, 4'h0);
    check("async_rst_ready", ready_v, 4'h0);
    check("async_rst_ce", ce_v, 4'h0);
    check("async_rst_ovf", ovf_v, 4'h0);
    check("async_rst_ret", ret_v[0], 32'h0);
    ap_start = 1'b0;
    tick(3);
    ap_rst_n = 1'b1;
    tick(2);
    run(5'd16, 1'b0);
    check("rerun_ret", ret_v[0], 32'h0000_0550);
    tick(2);

    // Back-to-back runs with ap_start held high
    run(5'd16, 1'b1);
    check("b2b_first_ret", ret_v[0], 32'h0000_0550);
    run(5'd16, 1'b0);
    check("b2b_second_ret", ret_v[0], 32'h0000_0550);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
